fir_ctrl_mc: RTL and testbench

FIR_CTRL_MC -- requirements
Module: fir_ctrl_mc

---
 rtl/fir_ctrl_mc.sv | 179 +++++++++++++++++
 tb/tb_fir_ctrl_mc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl_mc.sv
// fir_ctrl_mc: sequencer for a single-MAC FIR filter shared by NUM_CH
// time-multiplexed channels. Per accepted sample: one LOAD cycle, then for
// each channel NTAPS MAC cycles followed by one OUT cycle. All outputs are
// registered copies of the next-state decode, so val_in never reaches an
// output combinationally.
module fir_ctrl_mc #(
  parameter int NUM_COEF  = 17,
  parameter int NUM_CH    = 2,
  parameter int SYMMETRIC = 0,
  localparam int NTAPS = (SYMMETRIC != 0) ? (NUM_COEF + 1) / 2 : NUM_COEF,
  localparam int AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1,
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          val_in,
  output logic [AW-1:0] addr,
  output logic [CW-1:0] ch,
  output logic          ce_Reg,
  output logic          rst_Acc,
  output logic          ce_Acc,
  output logic          mid_tap,
  output logic          val_out,
  output logic          busy,
  output logic          overrun
);

  // Centre tap exists only when folding an odd-length filter.
  localparam bit MID_EN = (SYMMETRIC != 0) && ((NUM_COEF % 2) == 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NTAPS - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MAC  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] addr_r;
  logic [AW-1:0] addr_nxt_s;
  logic [CW-1:0] ch_r;
  logic [CW-1:0] ch_nxt_s;

  logic ce_reg_s;
  logic rst_acc_s;
  logic ce_acc_s;
  logic mid_tap_s;
  logic val_out_s;
  logic busy_s;

  logic ce_reg_r;
  logic rst_acc_r;
  logic ce_acc_r;
  logic mid_tap_r;
  logic val_out_r;
  logic busy_r;
  logic overrun_r;

  // State and tap/channel counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      ch_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      ch_r    <= ch_nxt_s;
    end
  end

  // Next-state and counter sequencing; >= compares keep counters bounded.
  always_comb begin
    state_nxt_s = ST_IDLE;
    addr_nxt_s  = '0;
    ch_nxt_s    = '0;
    case (state_r)
      ST_IDLE: begin
        if (val_in) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_MAC;
      end
      ST_MAC: begin
        ch_nxt_s = ch_r;
        if (addr_r >= ADDR_LAST) begin
          state_nxt_s = ST_OUT;
          addr_nxt_s  = ADDR_LAST;
        end else begin
          state_nxt_s = ST_MAC;
          addr_nxt_s  = addr_r + AW'(1);
        end
      end
      ST_OUT: begin
        if (ch_r >= CH_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MAC;
          ch_nxt_s    = ch_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state, registered below.
  always_comb begin
    ce_reg_s  = 1'b0;
    rst_acc_s = 1'b0;
    ce_acc_s  = 1'b0;
    mid_tap_s = 1'b0;
    val_out_s = 1'b0;
    busy_s    = 1'b1;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_LOAD: begin
        ce_reg_s = 1'b1;
      end
      ST_MAC: begin
        ce_acc_s  = 1'b1;
        rst_acc_s = (addr_nxt_s == '0);
        mid_tap_s = MID_EN && (addr_nxt_s == ADDR_LAST);
      end
      ST_OUT: begin
        val_out_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Output flops, plus the sticky overrun flag for samples dropped while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_reg_r  <= 1'b0;
      rst_acc_r <= 1'b0;
      ce_acc_r  <= 1'b0;
      mid_tap_r <= 1'b0;
      val_out_r <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      ce_reg_r  <= ce_reg_s;
      rst_acc_r <= rst_acc_s;
      ce_acc_r  <= ce_acc_s;
      mid_tap_r <= mid_tap_s;
      val_out_r <= val_out_s;
      busy_r    <= busy_s;
      if (val_in && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign addr    = addr_r;
  assign ch      = ch_r;
  assign ce_Reg  = ce_reg_r;
  assign rst_Acc = rst_acc_r;
  assign ce_Acc  = ce_acc_r;
  assign mid_tap = mid_tap_r;
  assign val_out = val_out_r;
  assign busy    = busy_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_fir_ctrl_mc.sv
// Testbench for fir_ctrl_mc: four parameterisations share one stimulus
// stream; each is tracked by a cycle-position model of the sample schedule.
module tb_fir_ctrl_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v   = 1'b0;

  always #5 clk = ~clk;

  // inst0: 17 coef, 2 ch, plain   inst1: 17 coef, 1 ch, folded
  // inst2: 16 coef, 1 ch, folded  inst3: 2 coef, 1 ch, plain
  logic [4:0] a0; logic [0:0] c0; logic cer0, rsa0, cea0, mid0, vo0, bsy0, ov0;
  logic [3:0] a1; logic [0:0] c1; logic cer1, rsa1, cea1, mid1, vo1, bsy1, ov1;
  logic [2:0] a2; logic [0:0] c2; logic cer2, rsa2, cea2, mid2, vo2, bsy2, ov2;
  logic [0:0] a3; logic [0:0] c3; logic cer3, rsa3, cea3, mid3, vo3, bsy3, ov3;

  fir_ctrl_mc #(.NUM_COEF(17), .NUM_CH(2), .SYMMETRIC(0)) u0 (
    .clk(clk), .rst(rst), .val_in(v), .addr(a0), .ch(c0), .ce_Reg(cer0),
    .rst_Acc(rsa0), .ce_Acc(cea0), .mid_tap(mid0), .val_out(vo0), .busy(bsy0), .overrun(ov0));
  fir_ctrl_mc #(.NUM_COEF(17), .NUM_CH(1), .SYMMETRIC(1)) u1 (
    .clk(clk), .rst(rst), .val_in(v), .addr(a1), .ch(c1), .ce_Reg(cer1),
    .rst_Acc(rsa1), .ce_Acc(cea1), .mid_tap(mid1), .val_out(vo1), .busy(bsy1), .overrun(ov1));
  fir_ctrl_mc #(.NUM_COEF(16), .NUM_CH(1), .SYMMETRIC(1)) u2 (
    .clk(clk), .rst(rst), .val_in(v), .addr(a2), .ch(c2), .ce_Reg(cer2),
    .rst_Acc(rsa2), .ce_Acc(cea2), .mid_tap(mid2), .val_out(vo2), .busy(bsy2), .overrun(ov2));
  fir_ctrl_mc #(.NUM_COEF(2), .NUM_CH(1), .SYMMETRIC(0)) u3 (
    .clk(clk), .rst(rst), .val_in(v), .addr(a3), .ch(c3), .ce_Reg(cer3),
    .rst_Acc(rsa3), .ce_Acc(cea3), .mid_tap(mid3), .val_out(vo3), .busy(bsy3), .overrun(ov3));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: per instance, position k inside the current sample (0 = idle).
  int NT[4] = '{17, 9, 8, 2};
  int NC[4] = '{2, 1, 1, 1};
  bit MO[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int mk[4] = '{0, 0, 0, 0};
  bit movr[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        mk[i] = 0;
        movr[i] = 1'b0;
      end else if (mk[i] == 0) begin
        if (v) mk[i] = 1;
      end else begin
        if (v) movr[i] = 1'b1;
        mk[i] = mk[i] + 1;
        if (mk[i] > 1 + NC[i] * (NT[i] + 1)) mk[i] = 0;
      end
    end
  endtask

  task automatic cmp_inst(input int i, input int aa, input int ac, input bit cer,
                          input bit rsa, input bit cea, input bit mid, input bit vo,
                          input bit bsy, input bit ovr);
    int k, j, c, p;
    int e_addr, e_ch;
    bit e_cer, e_rsa, e_cea, e_mid, e_vo, e_bsy, chk_addr;
    k = mk[i];
    e_addr = 0; e_ch = 0; chk_addr = 1'b1;
    e_cer = 0; e_rsa = 0; e_cea = 0; e_mid = 0; e_vo = 0; e_bsy = (k != 0);
    if (k == 1) begin
      e_cer = 1'b1;
    end else if (k >= 2) begin
      j = k - 2;
      c = j / (NT[i] + 1);
      p = j % (NT[i] + 1);
      e_ch = c;
      if (p < NT[i]) begin
        e_cea = 1'b1;
        e_addr = p;
        e_rsa = (p == 0);
        e_mid = MO[i] && (p == NT[i] - 1);
      end else begin
        e_vo = 1'b1;
        chk_addr = 1'b0;
      end
    end
    if (chk_addr) chk($sformatf("m%0d_addr", i), aa, e_addr);
    chk($sformatf("m%0d_ch", i), ac, e_ch);
    chk($sformatf("m%0d_ce_Reg", i), int'(cer), int'(e_cer));
    chk($sformatf("m%0d_rst_Acc", i), int'(rsa), int'(e_rsa));
    chk($sformatf("m%0d_ce_Acc", i), int'(cea), int'(e_cea));
    chk($sformatf("m%0d_mid_tap", i), int'(mid), int'(e_mid));
    chk($sformatf("m%0d_val_out", i), int'(vo), int'(e_vo));
    chk($sformatf("m%0d_busy", i), int'(bsy), int'(e_bsy));
    chk($sformatf("m%0d_overrun", i), int'(ovr), int'(movr[i]));
  endtask

  // One clock: model follows the inputs seen at the edge, DUTs checked 1 ns later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    cmp_inst(0, int'(a0), int'(c0), cer0, rsa0, cea0, mid0, vo0, bsy0, ov0);
    cmp_inst(1, int'(a1), int'(c1), cer1, rsa1, cea1, mid1, vo1, bsy1, ov1);
    cmp_inst(2, int'(a2), int'(c2), cer2, rsa2, cea2, mid2, vo2, bsy2, ov2);
    cmp_inst(3, int'(a3), int'(c3), cer3, rsa3, cea3, mid3, vo3, bsy3, ov3);
  endtask

  function automatic int qget(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  typedef struct {
    bit rst; bit v;
    int addr; int ch;
    bit cer; bit rsa; bit cea; bit mid; bit vo; bit bsy; bit ovr;
  } vec_t;

  vec_t tbl[13];
  int vq[$];
  int t0, nb0, nb1, nb2, nm1, nm2, ovf;

  initial begin
    // Hand-computed vectors for the 2-coefficient single-channel instance.
    // addr = -1 marks the OUT cycle where addr is not defined.
    tbl[0]  = '{1'b1, 1'b0,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1,  0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0,  0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0,  1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1,  0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1,  0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0,  1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1,  0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; v = 1'b0;
    step();
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; v = tbl[i].v;
      step();
      if (tbl[i].addr >= 0) chk($sformatf("t%0d_addr", i), int'(a3), tbl[i].addr);
      chk($sformatf("t%0d_ch", i), int'(c3), tbl[i].ch);
      chk($sformatf("t%0d_ce_Reg", i), int'(cer3), int'(tbl[i].cer));
      chk($sformatf("t%0d_rst_Acc", i), int'(rsa3), int'(tbl[i].rsa));
      chk($sformatf("t%0d_ce_Acc", i), int'(cea3), int'(tbl[i].cea));
      chk($sformatf("t%0d_mid_tap", i), int'(mid3), int'(tbl[i].mid));
      chk($sformatf("t%0d_val_out", i), int'(vo3), int'(tbl[i].vo));
      chk($sformatf("t%0d_busy", i), int'(bsy3), int'(tbl[i].bsy));
      chk($sformatf("t%0d_overrun", i), int'(ov3), int'(tbl[i].ovr));
    end
    rst = 1'b0; v = 1'b0;
    step();

    // Single pulse: timing, busy lengths and centre-tap counts.
    t0 = cyc; vq = {}; nb0 = 0; nb1 = 0; nb2 = 0; nm1 = 0; nm2 = 0;
    v = 1'b1;
    for (int n = 0; n < 45; n++) begin
      step();
      v = 1'b0;
      if (vo0) vq.push_back(cyc - t0);
      if (bsy0) nb0++;
      if (bsy1) nb1++;
      if (bsy2) nb2++;
      if (mid1) nm1++;
      if (mid2) nm2++;
      if (cyc - t0 == 1) chk("p_load", int'(cer0), 1);
      if (cyc - t0 == 18) chk("p_addr16", int'(a0), 16);
      if (cyc - t0 == 37) chk("p_ch1_out", int'(c0), 1);
    end
    chk("p_vout_n", vq.size(), 2);
    chk("p_vout0", qget(vq, 0), 19);
    chk("p_vout1", qget(vq, 1), 37);
    chk("p_busy0", nb0, 37);
    chk("p_busy_sym17", nb1, 11);
    chk("p_busy_sym16", nb2, 10);
    chk("p_mid_sym17", nm1, 1);
    chk("p_mid_sym16", nm2, 0);

    // Second pulse while busy is dropped and raises overrun.
    rst = 1'b1; step(); rst = 1'b0;
    t0 = cyc; vq = {}; ovf = -1;
    v = 1'b1;
    for (int n = 0; n < 45; n++) begin
      step();
      v = (cyc == t0 + 5);
      if (vo0) vq.push_back(cyc - t0);
      if (ov0 && ovf < 0) ovf = cyc - t0;
    end
    chk("o_vout_n", vq.size(), 2);
    chk("o_vout0", qget(vq, 0), 19);
    chk("o_vout1", qget(vq, 1), 37);
    chk("o_first", ovf, 6);
    chk("o_sticky", int'(ov0), 1);

    // val_in held high: back-to-back acceptance.
    rst = 1'b1; step(); rst = 1'b0;
    t0 = cyc; vq = {};
    v = 1'b1;
    for (int n = 0; n < 80; n++) begin
      step();
      if (vo0) vq.push_back(cyc - t0);
      if (cyc - t0 == 39) chk("h_reload", int'(cer0), 1);
    end
    v = 1'b0;
    chk("h_vout_n", vq.size(), 4);
    chk("h_vout0", qget(vq, 0), 19);
    chk("h_vout1", qget(vq, 1), 37);
    chk("h_vout2", qget(vq, 2), 57);
    chk("h_vout3", qget(vq, 3), 75);
    chk("h_ovr", int'(ov0), 1);

    // Reset mid-MAC aborts the sample; a fresh one starts cleanly.
    rst = 1'b1; step(); rst = 1'b0;
    chk("r_ovr_clr", int'(ov0), 0);
    t0 = cyc; vq = {};
    v = 1'b1; step(); v = 1'b0;
    while (cyc < t0 + 10) begin
      step();
      if (vo0) vq.push_back(cyc - t0);
    end
    rst = 1'b1; step(); rst = 1'b0;
    chk("r_busy", int'(bsy0), 0);
    chk("r_ce_Acc", int'(cea0), 0);
    chk("r_addr", int'(a0), 0);
    step();
    v = 1'b1; step(); v = 1'b0;
    chk("r_load_t13", cyc - t0, 13);
    chk("r_load", int'(cer0), 1);
    for (int n = 0; n < 40; n++) begin
      step();
      if (vo0) vq.push_back(cyc - t0);
    end
    chk("r_vout_n", vq.size(), 2);
    chk("r_vout0", qget(vq, 0), 13 + 18);

    // Random traffic with occasional resets against the model.
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
